// File: rtl/counter_v7_bcd_if.sv
// Control and status bundle for the BCD counter.
// The counter takes the slave modport; a driver or bench takes the master modport.
interface counter_v7_bcd_if #(
  parameter int unsigned DIGITS = 2
) ();
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic [DIGITS-1:0]     digit_tick;
  logic                  tc;

  modport master (
    output en,
    output up,
    output load,
    output load_val,
    input  count,
    input  digit_tick,
    input  tc
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_val,
    output count,
    output digit_tick,
    output tc
  );
endinterface

// File: rtl/counter_v7_bcd.sv
// N-digit synchronous BCD up/down counter with parallel load and per-digit wrap pulses.
// Every digit shares one clock; carries are decoded combinationally, never rippled as clocks.
module counter_v7_bcd #(
  parameter int unsigned DIGITS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  counter_v7_bcd_if.slave  io_bus
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic [W-1:0]      w_count_d;
  logic [DIGITS-1:0] r_tick;
  logic [DIGITS-1:0] w_tick_d;
  logic [DIGITS-1:0] w_at9;
  logic [DIGITS-1:0] w_at0;
  logic [DIGITS-1:0] w_step;

  // A digit steps only when every lower digit sits at its wrap value for the current direction.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_at9[g] = (r_count[4*g +: 4] == 4'd9);
    assign w_at0[g] = (r_count[4*g +: 4] == 4'd0);
    if (g == 0) begin : g_lsd
      assign w_step[g] = 1'b1;
    end else begin : g_upper
      assign w_step[g] = io_bus.up ? (&w_at9[g-1:0]) : (&w_at0[g-1:0]);
    end
  end

  always_comb begin
    w_count_d = r_count;
    w_tick_d  = '0;
    if (io_bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        // Out-of-range load digits saturate so no non-BCD value is ever held.
        w_count_d[4*i +: 4] = (io_bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                                                                  : io_bus.load_val[4*i +: 4];
      end
    end else if (io_bus.en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_step[i]) begin
          if (io_bus.up) begin
            if (w_at9[i]) begin
              w_count_d[4*i +: 4] = 4'd0;
              w_tick_d[i]         = 1'b1;
            end else begin
              w_count_d[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            end
          end else begin
            if (w_at0[i]) begin
              w_count_d[4*i +: 4] = 4'd9;
              w_tick_d[i]         = 1'b1;
            end else begin
              w_count_d[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_tick  <= '0;
    end else begin
      r_count <= w_count_d;
      r_tick  <= w_tick_d;
    end
  end

  assign io_bus.count      = r_count;
  assign io_bus.digit_tick = r_tick;
  assign io_bus.tc         = io_bus.en & ~io_bus.load & (io_bus.up ? (&w_at9) : (&w_at0));

endmodule

// File: tb/tb_counter_v7_bcd.sv
// Bench for counter_v7_bcd: a decimal reference model feeds a scoreboard queue for the
// 2-digit instance; a 4-digit instance runs a full 10000-edge wrap.
module tb_counter_v7_bcd;

  logic clk;
  logic rst_n;

  counter_v7_bcd_if #(.DIGITS(2)) bus2 ();
  counter_v7_bcd_if #(.DIGITS(4)) bus4 ();

  counter_v7_bcd #(.DIGITS(2)) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus2.slave)
  );

  counter_v7_bcd #(.DIGITS(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: value kept as a plain integer 0..99.
  int unsigned m_val  = 0;
  logic [1:0]  m_tick = '0;
  logic [9:0]  sb_q[$];
  logic        last_tc;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd4(input int unsigned v);
    logic [15:0] r;
    int unsigned p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Drive one cycle on the falling edge, check tc, push the expected post-edge state,
  // then pop and compare after the rising edge.
  task automatic drive(input logic en, input logic up, input logic load, input logic [7:0] lv);
    int unsigned nv;
    logic [1:0]  nt;
    logic        exp_tc;
    logic [9:0]  e;
    int unsigned d0;
    int unsigned d1;
    @(negedge clk);
    bus2.en = en; bus2.up = up; bus2.load = load; bus2.load_val = lv;
    #1;
    exp_tc = en & ~load & (up ? (m_val == 99) : (m_val == 0));
    last_tc = bus2.tc;
    check("tc", 32'(bus2.tc), 32'(exp_tc));
    nv = m_val;
    nt = '0;
    if (load) begin
      d0 = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
      d1 = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
      nv = d1 * 10 + d0;
    end else if (en) begin
      if (up) begin
        nv    = (m_val + 1) % 100;
        nt[0] = (m_val % 10) == 9;
        nt[1] = m_val == 99;
      end else begin
        nv    = (m_val + 99) % 100;
        nt[0] = (m_val % 10) == 0;
        nt[1] = m_val == 0;
      end
    end
    sb_q.push_back({nt, to_bcd(nv)});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("count", 32'(bus2.count), 32'(e[7:0]));
      check("tick", 32'(bus2.digit_tick), 32'(e[9:8]));
    end
    m_val  = nv;
    m_tick = nt;
  endtask

  int unsigned n_t0, n_t1, n_tc, n_t01, n_t3;

  initial begin
    rst_n = 1'b0;
    bus2.en = 1'b1; bus2.up = 1'b1; bus2.load = 1'b0; bus2.load_val = '0;
    bus4.en = 1'b0; bus4.up = 1'b1; bus4.load = 1'b0; bus4.load_val = '0;
    last_tc = 1'b0;

    // Reset held with en=1.
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(bus2.count), 0);
    check("rst_tick", 32'(bus2.digit_tick), 0);
    check("rst_tc_up", 32'(bus2.tc), 0);
    @(negedge clk);
    bus2.en = 1'b0;
    rst_n   = 1'b1;

    // 100 up edges: full wrap.
    n_t0 = 0; n_t1 = 0; n_tc = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      n_t0 += 32'(bus2.digit_tick[0]);
      n_t1 += 32'(bus2.digit_tick[1]);
      n_tc += 32'(last_tc);
    end
    check("t2_tick0_pulses", n_t0, 10);
    check("t2_tick1_pulses", n_t1, 1);
    check("t2_tc_cycles", n_tc, 1);

    // Load 05 then count down through the wrap.
    drive(1'b0, 1'b0, 1'b1, 8'h05);
    n_t01 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      if (bus2.digit_tick == 2'b01) n_t01++;
    end
    check("t3_final", 32'(bus2.count), 32'h99);
    check("t3_tick01_none", n_t01, 0);

    // Clamp on load; load beats a simultaneous enable.
    drive(1'b1, 1'b1, 1'b1, 8'hAF);
    drive(1'b0, 1'b1, 1'b1, 8'h3C);
    drive(1'b1, 1'b0, 1'b1, 8'hC2);

    // Enable toggling around a digit carry.
    drive(1'b0, 1'b1, 1'b1, 8'h08);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Mid-cycle reset at 57.
    drive(1'b0, 1'b1, 1'b1, 8'h56);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count", 32'(bus2.count), 0);
    m_val = 0; m_tick = '0;
    @(negedge clk);
    bus2.en = 1'b0;
    rst_n   = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00);

    // Mid-cycle reset while a tick is live.
    drive(1'b0, 1'b1, 1'b1, 8'h59);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tick", 32'(bus2.digit_tick), 0);
    check("t6_async_count2", 32'(bus2.count), 0);
    m_val = 0; m_tick = '0;
    @(negedge clk);
    bus2.en = 1'b0;
    rst_n   = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 4-digit instance: 10000 up edges, one full wrap.
    @(negedge clk);
    bus4.en = 1'b1;
    n_t3 = 0;
    for (int k = 1; k <= 10000; k++) begin
      @(posedge clk);
      #1;
      n_t3 += 32'(bus4.digit_tick[3]);
      if (k == 1234 || k == 9999 || k == 10000)
        check("d4_count", 32'(bus4.count), 32'(to_bcd4(k % 10000)));
      if (k == 9999) check("d4_tc", 32'(bus4.tc), 1);
      if (k == 10000) check("d4_tick_all", 32'(bus4.digit_tick), 32'hF);
    end
    @(negedge clk);
    bus4.en = 1'b0;
    check("d4_tick3_pulses", n_t3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
